key_press_classifier: RTL and testbench

KEY_PRESS_CLASSIFIER -- requirements
Module: key_press_classifier

---
 rtl/key_press_pkg.sv | 14 +
 rtl/key_press_channel.sv | 100 ++++++++++
 rtl/key_press_classifier.sv | 57 +++++
 tb/tb_key_press_classifier.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/key_press_pkg.sv
// rtl/key_press_pkg.sv - shared defaults and event-type encoding for the key press classifier
package key_press_pkg;

  localparam int DEF_N_KEYS        = 12;
  localparam int DEF_LONG_CYCLES   = 30;
  localparam int DEF_MIN_CYCLES    = 2;
  localparam int DEF_REPEAT_CYCLES = 10;

  typedef enum logic {
    EV_SHORT = 1'b0,
    EV_LONG  = 1'b1
  } ev_type_e;

endpackage

// File: rtl/key_press_channel.sv
// rtl/key_press_channel.sv - one key channel: press counter, short/long release pulses, long_held decode
// Auto-repeat is compiled in only with KEY_PRESS_CLASSIFIER_REPEAT_EN.
module key_press_channel
  import key_press_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int MIN_CYCLES    = DEF_MIN_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic short_pulse,
  output logic long_pulse,
  output logic long_held,
  output logic repeat_pulse
);

  localparam int CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] LONG_C = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_CYCLES);

  if (!(MIN_CYCLES >= 1 && MIN_CYCLES < LONG_CYCLES && REPEAT_CYCLES >= 1)) begin : g_bad_params
    $error("key_press_channel: need 1 <= MIN_CYCLES < LONG_CYCLES and REPEAT_CYCLES >= 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          short_q, short_d;
  logic          long_q, long_d;

  // A release is a low sample while the counter is non-zero; its class comes from the pre-clear count.
  always_comb begin
    cnt_d   = '0;
    short_d = 1'b0;
    long_d  = 1'b0;
    if (key_in) begin
      cnt_d = (cnt_q == LONG_C) ? cnt_q : cnt_q + CW'(1);
    end else if (cnt_q != '0) begin
      short_d = (cnt_q >= MIN_C) && (cnt_q < LONG_C);
      long_d  = (cnt_q == LONG_C);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign long_held   = (cnt_q == LONG_C);

`ifdef KEY_PRESS_CLASSIFIER_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [CW-1:0] LONG_M1  = CW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q, rep_d;
  logic          rpt_q, rpt_d;

  // First repeat fires on the edge that saturates the counter, then every REPEAT_CYCLES edges.
  always_comb begin
    rep_d = '0;
    rpt_d = 1'b0;
    if (key_in) begin
      if (cnt_q == LONG_M1) begin
        rpt_d = 1'b1;
      end else if (cnt_q == LONG_C) begin
        if (rep_q == REP_LAST) begin
          rpt_d = 1'b1;
        end else begin
          rep_d = rep_q + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q <= '0;
      rpt_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
      rpt_q <= rpt_d;
    end
  end

  assign repeat_pulse = rpt_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_press_classifier.sv
// rtl/key_press_classifier.sv - N_KEYS independent press classifiers plus lowest-index event encoder
// Optional auto-repeat is enabled by defining KEY_PRESS_CLASSIFIER_REPEAT_EN.
module key_press_classifier
  import key_press_pkg::*;
#(
  parameter int N_KEYS        = DEF_N_KEYS,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int MIN_CYCLES    = DEF_MIN_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int KW            = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] short_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] long_held,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              event_valid,
  output logic [KW-1:0]     event_key,
  output logic              event_long
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_press_channel #(
      .LONG_CYCLES  (LONG_CYCLES),
      .MIN_CYCLES   (MIN_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .key_in      (key_in[g]),
      .short_pulse (short_pulse[g]),
      .long_pulse  (long_pulse[g]),
      .long_held   (long_held[g]),
      .repeat_pulse(repeat_pulse[g])
    );
  end

  ev_type_e ev_type;

  // Scan from the top down so the lowest pulsing index is the last one written.
  always_comb begin
    event_valid = 1'b0;
    event_key   = '0;
    ev_type     = EV_SHORT;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (short_pulse[i] || long_pulse[i]) begin
        event_valid = 1'b1;
        event_key   = KW'(i);
        ev_type     = long_pulse[i] ? EV_LONG : EV_SHORT;
      end
    end
    event_long = event_valid && (ev_type == EV_LONG);
  end

endmodule

// File: tb/tb_key_press_classifier.sv
// tb/tb_key_press_classifier.sv - directed self-checking bench for key_press_classifier
module tb_key_press_classifier;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] key_in;
    logic [11:0] short_pulse, long_pulse, long_held, repeat_pulse;
    logic        event_valid, event_long;
    logic [3:0]  event_key;

    int vecs = 0;
    int errs = 0;

    key_press_classifier dut (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .long_held   (long_held),
        .repeat_pulse(repeat_pulse),
        .event_valid (event_valid),
        .event_key   (event_key),
        .event_long  (event_long)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] rep_exp(int ch, int sample);
        logic [11:0] r;
        r = '0;
`ifdef KEY_PRESS_CLASSIFIER_REPEAT_EN
        if (sample == 30 || sample == 40 || sample == 50) r[ch] = 1'b1;
`endif
        return r;
    endfunction

    initial begin
        reset  = 1'b1;
        key_in = '0;
        tick(); tick(); tick();
        chk("reset_short", short_pulse, 12'h000);
        chk("reset_long", long_pulse, 12'h000);
        chk("reset_held", long_held, 12'h000);
        chk("reset_repeat", repeat_pulse, 12'h000);
        chk("reset_evalid", 12'(event_valid), 12'h000);
        chk("reset_ekey", 12'(event_key), 12'h000);
        reset = 1'b0;
        tick();

        key_in[3] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("k3_no_pulse_while_held", short_pulse | long_pulse, 12'h000);
        key_in[3] = 1'b0;
        tick();
        chk("k3_short", short_pulse, 12'h008);
        chk("k3_long", long_pulse, 12'h000);
        chk("k3_evalid", 12'(event_valid), 12'h001);
        chk("k3_ekey", 12'(event_key), 12'd3);
        chk("k3_elong", 12'(event_long), 12'h000);
        tick();
        chk("k3_pulse_one_cycle", short_pulse, 12'h000);
        chk("k3_evalid_off", 12'(event_valid), 12'h000);
        chk("k3_ekey_zero", 12'(event_key), 12'h000);

        key_in[4] = 1'b1;
        tick(); tick();
        key_in[4] = 1'b0;
        tick();
        chk("k4_min_short", short_pulse, 12'h010);
        tick();

        key_in[4] = 1'b1;
        for (int i = 0; i < 29; i++) tick();
        chk("k4_29_not_held", long_held, 12'h000);
        key_in[4] = 1'b0;
        tick();
        chk("k4_29_short", short_pulse, 12'h010);
        chk("k4_29_long", long_pulse, 12'h000);
        tick();

        key_in[10] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk("k10_held", long_held, (i >= 30) ? 12'h400 : 12'h000);
            chk("k10_repeat", repeat_pulse, rep_exp(10, i));
        end
        key_in[10] = 1'b0;
        tick();
        chk("k10_long", long_pulse, 12'h400);
        chk("k10_short", short_pulse, 12'h000);
        chk("k10_held_falls", long_held, 12'h000);
        chk("k10_ekey", 12'(event_key), 12'd10);
        chk("k10_elong", 12'(event_long), 12'h001);
        tick();
        chk("k10_long_one_cycle", long_pulse, 12'h000);

        key_in[0] = 1'b1;
        tick();
        key_in[0] = 1'b0;
        tick();
        chk("k0_glitch_pulses", short_pulse | long_pulse, 12'h000);
        chk("k0_glitch_evalid", 12'(event_valid), 12'h000);
        tick();
        chk("k0_glitch_after", short_pulse | long_pulse, 12'h000);

        key_in[7] = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        key_in[2] = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        key_in[2] = 1'b0;
        key_in[7] = 1'b0;
        tick();
        chk("k2k7_short", short_pulse, 12'h004);
        chk("k2k7_long", long_pulse, 12'h080);
        chk("k2k7_ekey", 12'(event_key), 12'd2);
        chk("k2k7_elong", 12'(event_long), 12'h000);
        chk("k2k7_evalid", 12'(event_valid), 12'h001);
        tick();

        key_in[5] = 1'b1;
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b1;
        tick();
        chk("k5_reset_pulses", short_pulse | long_pulse, 12'h000);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("k5_no_long", long_pulse, 12'h000);
        end
        chk("k5_not_held", long_held, 12'h000);
        key_in[5] = 1'b0;
        tick();
        chk("k5_short", short_pulse, 12'h020);
        chk("k5_long", long_pulse, 12'h000);
        chk("k5_ekey", 12'(event_key), 12'd5);
        tick();

        key_in[1] = 1'b1;
        for (int i = 1; i <= 55; i++) begin
            tick();
            chk("k1_repeat", repeat_pulse, rep_exp(1, i));
        end
        key_in[1] = 1'b0;
        tick();
        chk("k1_long", long_pulse, 12'h002);
        chk("k1_repeat_stops", repeat_pulse, 12'h000);
        chk("k1_elong", 12'(event_long), 12'h001);
        chk("k1_ekey", 12'(event_key), 12'd1);
        tick();
        chk("k1_quiet", long_pulse | repeat_pulse, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
